td_sync_monitor: RTL and testbench
==================================

// Module: td_sync_monitor
// PURPOSE
//  Upstream of the 2-bit TV-decoder status PIO. Watches the raw ADV7180 sync
//  strobes (TD_HS, TD_VS), which are asynchronous to clk. Qualifies each
//  field by its line count and produces status[1:0] = {locked, video_present}.
//  status drives the PIO in_port directly; software polls it over Avalon.
// PARAMETERS
//  SYNC_STAGES  2          synchronizer flops per sync input (>=2)
//  VS_TIMEOUT   2_500_000  clk cycles with no VS edge before NO_SIGNAL (50 ms @ 50 MHz)
//  LINES_MIN    250        minimum HS edges per field for a valid field
//  LINES_MAX    320        maximum HS edges per field for a valid field
//  LOCK_FIELDS  4          consecutive valid fields needed for lock
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  td_hs       in   1   raw horizontal sync, active-low, async to clk
//  td_vs       in   1   raw vertical sync, active-low, async to clk
//  status      out  2   [0] video_present, [1] locked; registered
//  line_count  out  10  line count of the last completed field; registered
//  loss_flag   out  1   (TD_SYNC_LOSS_LATCH_EN only) sticky loss-of-lock
//  loss_clr    in   1   (TD_SYNC_LOSS_LATCH_EN only) 1-cycle clear pulse
// BEHAVIOUR
//  - One clock: clk. Reset is asynchronous and active-low (reset_n). Every
//    register clears on reset: state=NO_SIGNAL, status=2'b00, line_count=0,
//    counters=0, loss_flag=0. Reset mid-field discards all progress.
//  - Sync inputs pass through SYNC_STAGES flops plus one edge-detect flop.
//    The event is the falling edge (1->0), a 1-cycle pulse hs_ev / vs_ev.
//  - Line counter: +1 on hs_ev, saturates at 1023. On vs_ev the counter's
//    current value is judged, copied to line_count, and the counter is set to 0.
//    hs_ev in the same cycle as vs_ev is dropped (neither judged nor counted).
//  - Field valid iff LINES_MIN <= count <= LINES_MAX. A saturated count is invalid.
//  - Timeout counter: cleared on vs_ev, otherwise +1. At VS_TIMEOUT it forces
//    NO_SIGNAL from any state. vs_ev in the same cycle wins (no timeout).
//  - FSM, with good_cnt = count of consecutive valid fields:
//    NO_SIGNAL : vs_ev -> ACQUIRE, good_cnt=0. The first field is partial and
//                is not judged.
//    ACQUIRE   : valid vs_ev -> good_cnt+1. On reaching LOCK_FIELDS -> LOCKED.
//                invalid vs_ev -> good_cnt=0, stay in ACQUIRE.
//    LOCKED    : invalid vs_ev -> ACQUIRE, good_cnt=0. Valid vs_ev -> stay.
//  - status is registered from the next-state decode: {state==LOCKED,
//    state!=NO_SIGNAL}. It updates on the same edge as the state register.
//    Latency from a td_vs pin edge to a status change is SYNC_STAGES+2 clks.
// CONFIGURATION
//  - TD_SYNC_LOSS_LATCH_EN defined: adds ports loss_flag and loss_clr.
//    loss_flag is set on any transition out of LOCKED, and is cleared by
//    loss_clr. Set wins when both occur in the same cycle.
//  - TD_SYNC_LOSS_LATCH_EN undefined: those ports and their logic are absent.
//    status behaves identically in both builds.
// STRUCTURE
//  - Package td_sync_pkg:
//    - state enum {NO_SIGNAL=2'd0, ACQUIRE=2'd1, LOCKED=2'd2}
//    - LINE_W=10, status bit indices STAT_PRESENT=0, STAT_LOCKED=1
//  - Sub-module td_sync_edge (param SYNC_STAGES): synchronizer chain plus
//    falling-edge pulse. Instantiated twice, once for HS and once for VS.
//  - Top holds the line counter, timeout counter, FSM and output registers.
// TESTING  (bench overrides VS_TIMEOUT=1000, LOCK_FIELDS=4)
//  1 Release reset with no sync activity. Expect status=00 and line_count=0,
//    held for >2000 clks.
//  2 Drive 5 fields of 262 HS pulses each. Expect status=01 after the 1st VS.
//    Expect status=11 exactly SYNC_STAGES+2 clks after the 5th VS edge.
//    Expect line_count=262.
//  3 From LOCKED, send one field of 200 lines. Expect status=01 and
//    line_count=200. Then 4 good fields -> 11.
//  4 From LOCKED, stop VS. Expect status=00 exactly 1000 clks after the last
//    vs_ev. Check loss_flag=1 if enabled. Then loss_clr -> loss_flag=0.
//  5 Drive HS and VS edges that land on the same synchronized cycle. Expect
//    that HS is not counted in either field (next line_count = HS pulses - 1).
//  6 Assert reset_n low mid-field while LOCKED. Expect status=00 immediately,
//    asynchronously. After release, reacquisition needs a fresh 1+4 VS edges.

Source files
------------

// File: rtl/td_sync_pkg.sv
// Shared types and constants for the TV-decoder sync monitor.
// Holds the FSM state encoding, status bit positions and the field judge.
package td_sync_pkg;

  localparam int LINE_W       = 10;
  localparam int STAT_PRESENT = 0;
  localparam int STAT_LOCKED  = 1;

  localparam logic [LINE_W-1:0] LINE_SAT = '1;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    ACQUIRE   = 2'd1,
    LOCKED    = 2'd2
  } sync_state_t;

  // A saturated count means the field overflowed, so it can never be valid.
  function automatic logic field_valid(input logic [LINE_W-1:0] count,
                                       input int lines_min,
                                       input int lines_max);
    return (count != LINE_SAT) &&
           (int'(count) >= lines_min) &&
           (int'(count) <= lines_max);
  endfunction

endpackage

// File: rtl/td_sync_edge.sv
// Synchronizer chain for one raw sync strobe, followed by a registered
// one-cycle pulse on each synchronized falling edge.
module td_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_raw,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops clear to 0, so an idle-high strobe never fakes a falling edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sync_raw};
      prev_q     <= sync_q[SYNC_STAGES-1];
      fall_pulse <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/td_sync_monitor.sv
// Qualifies ADV7180 fields by line count and reports {locked, video_present}.
// Optional sticky loss-of-lock flag enabled by defining TD_SYNC_LOSS_LATCH_EN.
module td_sync_monitor
  import td_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VS_TIMEOUT  = 2_500_000,
  parameter int LINES_MIN   = 250,
  parameter int LINES_MAX   = 320,
  parameter int LOCK_FIELDS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              td_hs,
  input  logic              td_vs,
`ifdef TD_SYNC_LOSS_LATCH_EN
  input  logic              loss_clr,
  output logic              loss_flag,
`endif
  output logic [1:0]        status,
  output logic [LINE_W-1:0] line_count
);

  localparam int TMO_W  = $clog2(VS_TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_FIELDS + 1);

  logic              hs_ev;
  logic              vs_ev;
  logic [LINE_W-1:0] line_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              timeout_hit;
  logic              field_ok;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] next_good;
  sync_state_t       state;
  sync_state_t       next_state;

  td_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hs_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_raw   (td_hs),
    .fall_pulse (hs_ev)
  );

  td_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vs_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_raw   (td_vs),
    .fall_pulse (vs_ev)
  );

  // An HS landing on the VS cycle belongs to neither field, so vs_ev takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt   <= '0;
      line_count <= '0;
    end else if (vs_ev) begin
      line_cnt   <= '0;
      line_count <= line_cnt;
    end else if (hs_ev && (line_cnt != LINE_SAT)) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (vs_ev) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(VS_TIMEOUT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = !vs_ev && (tmo_cnt >= TMO_W'(VS_TIMEOUT - 1));
  assign field_ok    = field_valid(line_cnt, LINES_MIN, LINES_MAX);

  always_comb begin
    next_state = state;
    next_good  = good_cnt;
    case (state)
      NO_SIGNAL: begin
        if (vs_ev) begin
          next_state = ACQUIRE;
          next_good  = '0;
        end
      end
      ACQUIRE: begin
        if (vs_ev) begin
          if (field_ok) begin
            next_good = good_cnt + 1'b1;
            if (good_cnt == GOOD_W'(LOCK_FIELDS - 1)) begin
              next_state = LOCKED;
            end
          end else begin
            next_good = '0;
          end
        end
      end
      LOCKED: begin
        if (vs_ev && !field_ok) begin
          next_state = ACQUIRE;
          next_good  = '0;
        end
      end
      default: begin
        next_state = NO_SIGNAL;
        next_good  = '0;
      end
    endcase
    if (timeout_hit) begin
      next_state = NO_SIGNAL;
      next_good  = '0;
    end
  end

  // status decodes next_state so it moves on the same edge as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= NO_SIGNAL;
      good_cnt <= '0;
      status   <= 2'b00;
    end else begin
      state                <= next_state;
      good_cnt             <= next_good;
      status[STAT_LOCKED]  <= (next_state == LOCKED);
      status[STAT_PRESENT] <= (next_state != NO_SIGNAL);
    end
  end

`ifdef TD_SYNC_LOSS_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_flag <= 1'b0;
    end else if ((state == LOCKED) && (next_state != LOCKED)) begin
      loss_flag <= 1'b1;
    end else if (loss_clr) begin
      loss_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_td_sync_monitor.sv
// Directed self-checking bench for td_sync_monitor (VS_TIMEOUT=1000, LOCK_FIELDS=4).
// Each sync line is a 1-clk low pulse; status moves 4 clks after a pin edge.
module tb_td_sync_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       td_hs = 1'b1;
  logic       td_vs = 1'b1;
  logic [1:0] status;
  logic [9:0] line_count;
`ifdef TD_SYNC_LOSS_LATCH_EN
  logic       loss_clr = 1'b0;
  logic       loss_flag;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  td_sync_monitor #(
    .SYNC_STAGES (2),
    .VS_TIMEOUT  (1000),
    .LINES_MIN   (250),
    .LINES_MAX   (320),
    .LOCK_FIELDS (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .td_hs      (td_hs),
    .td_vs      (td_vs),
`ifdef TD_SYNC_LOSS_LATCH_EN
    .loss_clr   (loss_clr),
    .loss_flag  (loss_flag),
`endif
    .status     (status),
    .line_count (line_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line();
    td_hs = 1'b0;
    tick();
    td_hs = 1'b1;
    tick();
  endtask

  task automatic send_vs();
    td_vs = 1'b0;
    tick();
    td_vs = 1'b1;
    tick();
  endtask

  task automatic send_both();
    td_hs = 1'b0;
    td_vs = 1'b0;
    tick();
    td_hs = 1'b1;
    td_vs = 1'b1;
    tick();
  endtask

  // After this returns, two more ticks reach the edge where status reacts.
  task automatic send_field(input int lines);
    repeat (lines) send_line();
    send_vs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (status !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_status: got %b expected 00", status);
    end
    checks++;
    if (line_count !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_line_count: got %0d expected 0", line_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      repeat (100) tick();
      checks++;
      if (status !== 2'b00 || line_count !== 10'd0) begin
        failures++;
        $display("[TB] FAIL idle_hold: status %b line_count %0d expected 00 / 0", status, line_count);
      end
    end
  endtask

  task automatic test_lock();
    for (int f = 0; f < 5; f++) begin
      send_field(262);
      tick();
      if (f < 4) begin
        tick();
        checks++;
        if (status !== 2'b01) begin
          failures++;
          $display("[TB] FAIL acquire_status f%0d: got %b expected 01", f, status);
        end
      end else begin
        checks++;
        if (status !== 2'b01) begin
          failures++;
          $display("[TB] FAIL lock_too_early: got %b expected 01", status);
        end
        tick();
        checks++;
        if (status !== 2'b11) begin
          failures++;
          $display("[TB] FAIL lock_latency: got %b expected 11", status);
        end
      end
    end
    checks++;
    if (line_count !== 10'd262) begin
      failures++;
      $display("[TB] FAIL lock_line_count: got %0d expected 262", line_count);
    end
  endtask

  task automatic test_short_field();
    send_field(200);
    tick();
    tick();
    checks++;
    if (status !== 2'b01 || line_count !== 10'd200) begin
      failures++;
      $display("[TB] FAIL short_field: status %b line_count %0d expected 01 / 200", status, line_count);
    end
    for (int f = 0; f < 4; f++) begin
      send_field(262);
      tick();
      tick();
      checks++;
      if (status !== ((f == 3) ? 2'b11 : 2'b01)) begin
        failures++;
        $display("[TB] FAIL relock f%0d: got %b expected %b", f, status, (f == 3) ? 2'b11 : 2'b01);
      end
    end
  endtask

  task automatic test_boundaries();
    send_field(250);
    tick();
    tick();
    checks++;
    if (status !== 2'b11 || line_count !== 10'd250) begin
      failures++;
      $display("[TB] FAIL min_lines: status %b line_count %0d expected 11 / 250", status, line_count);
    end
    send_field(320);
    tick();
    tick();
    checks++;
    if (status !== 2'b11 || line_count !== 10'd320) begin
      failures++;
      $display("[TB] FAIL max_lines: status %b line_count %0d expected 11 / 320", status, line_count);
    end
    send_field(321);
    tick();
    tick();
    checks++;
    if (status !== 2'b01 || line_count !== 10'd321) begin
      failures++;
      $display("[TB] FAIL over_max: status %b line_count %0d expected 01 / 321", status, line_count);
    end
`ifdef TD_SYNC_LOSS_LATCH_EN
    checks++;
    if (loss_flag !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loss_on_invalid: got %b expected 1", loss_flag);
    end
`endif
    repeat (4) send_field(262);
    tick();
    tick();
    checks++;
    if (status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL relock_after_max: got %b expected 11", status);
    end
    send_field(249);
    tick();
    tick();
    checks++;
    if (status !== 2'b01 || line_count !== 10'd249) begin
      failures++;
      $display("[TB] FAIL under_min: status %b line_count %0d expected 01 / 249", status, line_count);
    end
    repeat (4) send_field(262);
    tick();
    tick();
    checks++;
    if (status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL relock_after_min: got %b expected 11", status);
    end
  endtask

  task automatic test_back_to_back();
    repeat (261) send_line();
    send_both();
    tick();
    tick();
    checks++;
    if (line_count !== 10'd261 || status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL coincident_drop_a: line_count %0d status %b expected 261 / 11", line_count, status);
    end
    send_field(262);
    tick();
    tick();
    checks++;
    if (line_count !== 10'd262 || status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL coincident_drop_b: line_count %0d status %b expected 262 / 11", line_count, status);
    end
  endtask

  task automatic test_timeout();
`ifdef TD_SYNC_LOSS_LATCH_EN
    loss_clr = 1'b1;
    tick();
    loss_clr = 1'b0;
    checks++;
    if (loss_flag !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loss_clear_pre: got %b expected 0", loss_flag);
    end
`endif
    send_field(262);
    repeat (1001) tick();
    checks++;
    if (status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL timeout_early: got %b expected 11", status);
    end
    tick();
    checks++;
    if (status !== 2'b00) begin
      failures++;
      $display("[TB] FAIL timeout_exact: got %b expected 00", status);
    end
`ifdef TD_SYNC_LOSS_LATCH_EN
    checks++;
    if (loss_flag !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loss_on_timeout: got %b expected 1", loss_flag);
    end
    loss_clr = 1'b1;
    tick();
    loss_clr = 1'b0;
    checks++;
    if (loss_flag !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loss_clear: got %b expected 0", loss_flag);
    end
`endif
  endtask

  task automatic test_reset_midfield();
    repeat (5) send_field(262);
    tick();
    tick();
    checks++;
    if (status !== 2'b11) begin
      failures++;
      $display("[TB] FAIL pre_reset_lock: got %b expected 11", status);
    end
    repeat (100) send_line();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (status !== 2'b00 || line_count !== 10'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: status %b line_count %0d expected 00 / 0", status, line_count);
    end
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    for (int f = 0; f < 5; f++) begin
      send_field(262);
      tick();
      tick();
      checks++;
      if (status !== ((f == 4) ? 2'b11 : 2'b01)) begin
        failures++;
        $display("[TB] FAIL reacquire f%0d: got %b expected %b", f, status, (f == 4) ? 2'b11 : 2'b01);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_field();
    test_boundaries();
    test_back_to_back();
    test_timeout();
    test_reset_midfield();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
